// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor: WIDTH bits processed CHUNK bits per clock,
// with valid/ready handshakes and registered carry/overflow/zero flags.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(WIDTH) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cy_q, cy_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SW-1:0]    shamt_s;
    logic [CHUNK-1:0] a_sl_s;
    logic [CHUNK-1:0] b_sl_s;
    logic [CHUNK:0]   add_s;
    logic             cin_msb_s;
    logic [WIDTH-1:0] sum_ins_s;

    // One ripple slice: CHUNK-bit sum with carry-out in the top bit.
    function automatic logic [CHUNK:0] slice_add(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             ci
    );
        slice_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
    endfunction

    // Slice datapath: select slice k of the captured operands and merge its sum into the result.
    always_comb begin
        shamt_s   = SW'(k_q) * SW'(CHUNK);
        a_sl_s    = CHUNK'(a_q >> shamt_s);
        b_sl_s    = CHUNK'(b_q >> shamt_s);
        add_s     = slice_add(a_sl_s, b_sl_s, cy_q);
        // Carry into the MSB is recovered from the MSB's own sum bit.
        cin_msb_s = a_sl_s[CHUNK-1] ^ b_sl_s[CHUNK-1] ^ add_s[CHUNK-1];
        sum_ins_s = sum_q | (WIDTH'(add_s[CHUNK-1:0]) << shamt_s);
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer and its datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        k_d     = k_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{m}};
                    cy_d    = m;
                    k_d     = {KW{1'b0}};
                    sum_d   = {WIDTH{1'b0}};
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d = sum_ins_s;
                cy_d  = add_s[CHUNK];
                if (k_q == K_LAST) begin
                    carry_d = add_s[CHUNK];
                    ovf_d   = cin_msb_s ^ add_s[CHUNK];
                    zero_d  = (sum_ins_s == {WIDTH{1'b0}});
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            cy_q    <= 1'b0;
            k_q     <= {KW{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // in_ready is the one output allowed to see rst combinationally.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Randomized bench for addsub_seq: four width/chunk configurations checked against an
// arithmetic reference model, plus directed corner cases, backpressure and mid-operation reset.
module tb_addsub_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic go_rand;
    logic done_f [4];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        localparam int C = (g == 0) ? 4  : (g == 1) ? 1 : (g == 2) ? 2 : 32;
        localparam int N = W / C;

        logic         iv, ordy, md;
        logic [W-1:0] ain, bin;
        logic [W-1:0] s;
        logic         ir, ov, cy, of, zr;

        addsub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir),
            .a(ain), .b(bin), .m(md), .out_valid(ov), .out_ready(ordy),
            .sum(s), .carry(cy), .overflow(of), .zero(zr)
        );

        // Reference: plain unsigned/signed integer arithmetic on the whole operands.
        function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic md_i,
                                      output logic [W-1:0] r, output logic c, output logic o,
                                      output logic z);
            longint ux, uy, sx, sy, full, st, lim;
            lim  = longint'(1) << W;
            ux   = longint'(x);
            uy   = longint'(y);
            sx   = x[W-1] ? ux - lim : ux;
            sy   = y[W-1] ? uy - lim : uy;
            if (md_i) begin
                full = ux - uy;
                c    = (ux >= uy);
                st   = sx - sy;
            end else begin
                full = ux + uy;
                c    = (full >= lim);
                st   = sx + sy;
            end
            r = W'(full);
            o = (st > (lim / 2) - 1) || (st < -(lim / 2));
            z = (r == '0);
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] v;
            case ($urandom_range(0, 5))
                0:       v = '1;
                1:       v = '0;
                2:       v = W'(1) << (W - 1);
                default: v = W'($urandom);
            endcase
            return v;
        endfunction

        task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tm,
                             input int stall);
            logic [W-1:0] er;
            logic         ec, eo, ez;
            int           lat;
            bit           got;
            model(ta, tbv, tm, er, ec, eo, ez);
            @(negedge clk);
            lat = 0;
            while (ir !== 1'b1 && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            chk("accept_ready", 64'(ir), 64'(1));
            iv = 1'b1; ain = ta; bin = tbv; md = tm;
            @(posedge clk);
            #1;
            iv = 1'b0; ain = W'($urandom); bin = W'($urandom); md = 1'($urandom);
            ordy = (stall == 0);
            lat = 0;
            got = 1'b0;
            while (!got && lat < N + 4) begin
                @(posedge clk);
                #1;
                lat++;
                got = (ov === 1'b1);
            end
            chk("latency", 64'(lat), 64'(N));
            chk("sum", 64'(s), 64'(er));
            chk("carry", 64'(cy), 64'(ec));
            chk("overflow", 64'(of), 64'(eo));
            chk("zero", 64'(zr), 64'(ez));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                iv = 1'($urandom); ain = W'($urandom); bin = W'($urandom); md = 1'($urandom);
                @(posedge clk);
                #1;
                chk("hold_sum", 64'(s), 64'(er));
                chk("hold_flags", 64'({cy, of, zr}), 64'({ec, eo, ez}));
                chk("hold_busy", 64'({ov, ir}), 64'(2'b10));
            end
            @(negedge clk);
            iv = 1'b0; ordy = 1'b1;
            @(posedge clk);
            #1;
            chk("release", 64'({ov, ir}), 64'(2'b01));
            ordy = 1'b0;
        endtask

        task automatic rand_ops(input int n);
            for (int i = 0; i < n; i++) begin
                do_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3));
            end
        endtask

        if (g == 0) begin : g_main
            initial begin
                done_f[g] = 1'b0;
                go_rand = 1'b0;
                iv = 1'b0; ordy = 1'b0; ain = '0; bin = '0; md = 1'b0;
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_flags", 64'({ov, cy, of, zr}), 64'(4'b0000));
                chk("rst_sum", 64'(s), 64'(0));
                chk("rst_ready", 64'(ir), 64'(0));
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("ready_after_rst", 64'(ir), 64'(1));
                do_op(16'h7FFF, 16'h0001, 1'b0, 0);
                do_op(16'h0000, 16'h0001, 1'b1, 1);
                do_op(16'hFFFF, 16'h0001, 1'b0, 0);
                do_op(16'h8000, 16'h0001, 1'b1, 2);
                do_op(16'h1357, 16'h2468, 1'b0, 5);
                // Abort an operation after two of its four slices.
                @(negedge clk);
                iv = 1'b1; ain = 16'hABCD; bin = 16'h1111; md = 1'b0;
                @(posedge clk);
                #1;
                iv = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("midrun_flags", 64'({ov, cy, of, zr}), 64'(4'b0000));
                chk("midrun_sum", 64'(s), 64'(0));
                chk("midrun_ready", 64'(ir), 64'(0));
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("midrun_idle", 64'({ov, ir}), 64'(2'b01));
                do_op(16'h1234, 16'h1111, 1'b0, 0);
                chk("after_abort_sum", 64'(s), 64'(16'h2345));
                go_rand = 1'b1;
                rand_ops(60);
                done_f[g] = 1'b1;
            end
        end else if (g == 1) begin : g_narrow
            initial begin
                done_f[g] = 1'b0;
                iv = 1'b0; ordy = 1'b0; ain = '0; bin = '0; md = 1'b0;
                wait (go_rand === 1'b1);
                do_op(4'hF, 4'hF, 1'b1, 0);
                chk("f_minus_f", 64'({s, cy, of, zr}), 64'(7'b0000_1_0_1));
                do_op(4'h0, 4'h0, 1'b0, 1);
                chk("zero_plus_zero", 64'({s, cy, zr}), 64'(6'b0000_0_1));
                rand_ops(60);
                done_f[g] = 1'b1;
            end
        end else begin : g_other
            initial begin
                done_f[g] = 1'b0;
                iv = 1'b0; ordy = 1'b0; ain = '0; bin = '0; md = 1'b0;
                wait (go_rand === 1'b1);
                rand_ops(60);
                done_f[g] = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (done_f[0] === 1'b1 && done_f[1] === 1'b1 &&
                  done_f[2] === 1'b1 && done_f[3] === 1'b1);
            #500000;
        join_any
        disable fork;
        chk("all_done", 64'({done_f[0], done_f[1], done_f[2], done_f[3]}), 64'(4'hF));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle two's-complement adder/subtractor with valid/ready handshakes. A WIDTH-bit operation is processed as WIDTH/CHUNK ripple-carry slices, one slice per clock, with a mode bit selecting add or subtract (B inverted, carry-in = mode). It generalises the team's 4-bit combinational add/sub datapath into a registered, width-scalable arithmetic unit with status flags, for use wherever area matters more than single-cycle latency.

## Interface

- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK slice cycles.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set on a/b/m is valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- m  input  1  mode: 0 = A+B, 1 = A−B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry  output  1  carry-out of MSB; in subtract mode 1 = no borrow (A ≥ B unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready: latch a, latch b XOR {WIDTH{m}}, set carry register = m, clear slice counter and result register, go to RUN.
- RUN: each cycle add slice k (bits k*CHUNK .. k*CHUNK+CHUNK−1) of A and B' plus carry register; write slice k of sum, update carry register, k ← k+1. On the last slice (k = N−1), also capture carry-into-MSB for overflow, compute zero from the complete sum, go to DONE.
- DONE: out_valid = 1; sum/carry/overflow/zero held stable. On out_ready go to IDLE.
- in_ready is 0 in RUN and DONE; in_valid ignored there (no queuing).
- Operands are captured at accept; changes to a/b/m after accept have no effect.
- Reset (any state, including mid-RUN or DONE with a stalled result): next state IDLE, out_valid = 0, sum = 0, carry = overflow = zero = 0, slice counter = 0; in-flight operation discarded. in_ready = 0 while rst is high.

## Timing

- Accept edge = cycle 0. Slices processed on edges 1..N. out_valid rises after edge N, i.e. latency N cycles from accept to first out_valid cycle (N = 4 at defaults).
- Output handshake completes on the edge where out_valid && out_ready; in_ready = 1 the following cycle. Minimum initiation interval: N+2 cycles (accept, N slices, output handshake returns to IDLE).
- out_ready held low: DONE persists indefinitely, outputs unchanged.
- out_ready asserted before out_valid has no effect.
- CHUNK = WIDTH: N = 1, single RUN cycle.
- Flags are registered with sum; no combinational path from inputs to outputs except rst → in_ready.

## Test plan

- WIDTH=4, CHUNK=1: A=1111, B=1111, m=1 -> sum=0000, carry=1, overflow=0, zero=1, out_valid 4 cycles after accept; A=0000, B=0000, m=0 -> sum=0000, carry=0, zero=1.
- WIDTH=16, CHUNK=4: A=0x7FFF, B=0x0001, m=0 -> sum=0x8000, carry=0, overflow=1, zero=0; A=0x0000, B=0x0001, m=1 -> sum=0xFFFF, carry=0, overflow=0.
- Defaults: A=0xFFFF, B=0x0001, m=0 -> sum=0x0000, carry=1, overflow=0, zero=1; A=0x8000, B=0x0001, m=1 -> sum=0x7FFF, overflow=1, carry=1.
- Backpressure: out_ready low 5 cycles after out_valid -> outputs constant, in_ready=0, toggled in_valid/a/b ignored; out_ready high -> in_ready=1 next cycle.
- Reset mid-RUN (after slice 2 of 4) -> next cycle out_valid=0, sum=0, flags 0, IDLE; subsequent op 0x1234+0x1111 -> 0x2345.
- Randomized regression across WIDTH∈{4,8,16,32}, CHUNK∈{1,2,4,WIDTH} with random stalls -> sum/carry/overflow/zero match a reference model for every op; latency exactly N.
